// File: rtl/obstacle_alert_ctrl.sv
// Obstacle-alert controller: per-channel sync + debounce, popcount, beep-pattern FSM.
// Optional build macro HAPTIC_VIBE_EN adds a registered vibration-motor drive on vibe_out.
//
// state    | meaning
// ---------+-------------------------------------------------
// IDLE     | silent; disabled or no channel detecting
// BEEP_ON  | buzzer on for ON_CYCLES
// BEEP_OFF | silent gap, length OFF_CYCLES >> (count-1), min 1
// CONT     | all channels detecting, continuous tone
module obstacle_alert_ctrl #(
   parameter int NUM_SENSORS     = 3,
   parameter int DEBOUNCE_CYCLES = 4,
   parameter int ON_CYCLES       = 8,
   parameter int OFF_CYCLES      = 24
) (
   input  logic                               clk,
   input  logic                               rst_n,
   input  logic                               enable,
   input  logic [NUM_SENSORS-1:0]             sensorpin,
   output logic [NUM_SENSORS-1:0]             sensor_active,
   output logic [$clog2(NUM_SENSORS+1)-1:0]   active_count,
   output logic                               buzzerpin,
   output logic                               vibe_out
);

   localparam int DW   = $clog2(DEBOUNCE_CYCLES + 1);
   localparam int CW   = $clog2(NUM_SENSORS + 1);
   localparam int PMAX = (ON_CYCLES > OFF_CYCLES) ? ON_CYCLES : OFF_CYCLES;
   localparam int PW   = $clog2(PMAX + 1);

   localparam logic [CW-1:0] N_C      = CW'(NUM_SENSORS);
   localparam logic [PW-1:0] OFF_C    = PW'(OFF_CYCLES);
   localparam logic [PW-1:0] ON_LAST  = PW'(ON_CYCLES - 1);
   localparam logic [DW-1:0] DEB_LAST = DW'(DEBOUNCE_CYCLES - 1);

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      BEEP_ON  = 2'd1,
      BEEP_OFF = 2'd2,
      CONT     = 2'd3
   } state_t;

   logic [NUM_SENSORS-1:0]          sync1_q, sync2_q;
   logic [NUM_SENSORS-1:0]          stable_q, stable_d;
   logic [NUM_SENSORS-1:0][DW-1:0]  dcnt_q, dcnt_d;
   logic [CW-1:0]                   cnt_q, cnt_d;
   logic [PW-1:0]                   pcnt_q, pcnt_d;
   logic [PW-1:0]                   gap_raw, gap;
   logic [CW-1:0]                   shamt;
   state_t                          state_q, state_d;

   // A channel flips only after DEBOUNCE_CYCLES consecutive disagreeing samples.
   always_comb begin
      stable_d = stable_q;
      dcnt_d   = '0;
      for (int i = 0; i < NUM_SENSORS; i++) begin
         if (sync2_q[i] != stable_q[i]) begin
            if (dcnt_q[i] == DEB_LAST) begin
               stable_d[i] = sync2_q[i];
            end else begin
               dcnt_d[i] = dcnt_q[i] + DW'(1);
            end
         end
      end
   end

   always_comb begin
      cnt_d = '0;
      for (int i = 0; i < NUM_SENSORS; i++) begin
         cnt_d = cnt_d + CW'(stable_q[i]);
      end
   end

   always_comb begin
      shamt   = (cnt_q == '0) ? '0 : cnt_q - CW'(1);
      gap_raw = OFF_C >> shamt;
      gap     = (gap_raw == '0) ? PW'(1) : gap_raw;
   end

   always_comb begin
      state_d = state_q;
      if (!enable || cnt_q == '0) begin
         state_d = IDLE;
      end else begin
         case (state_q)
            IDLE:     state_d = (cnt_q == N_C) ? CONT : BEEP_ON;
            BEEP_ON: begin
               if (cnt_q == N_C)          state_d = CONT;
               else if (pcnt_q == ON_LAST) state_d = BEEP_OFF;
            end
            BEEP_OFF: begin
               if (cnt_q == N_C)                state_d = CONT;
               else if (pcnt_q >= gap - PW'(1)) state_d = BEEP_ON;
            end
            CONT:     if (cnt_q != N_C) state_d = BEEP_OFF;
            default:  state_d = IDLE;
         endcase
      end
   end

   // pcnt restarts on every state change and only runs inside the beep phases.
   always_comb begin
      pcnt_d = '0;
      if (state_d == state_q && (state_q == BEEP_ON || state_q == BEEP_OFF)) begin
         pcnt_d = pcnt_q + PW'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync1_q  <= '0;
         sync2_q  <= '0;
         stable_q <= '0;
         dcnt_q   <= '0;
         cnt_q    <= '0;
         pcnt_q   <= '0;
         state_q  <= IDLE;
      end else begin
         sync1_q  <= sensorpin;
         sync2_q  <= sync1_q;
         stable_q <= stable_d;
         dcnt_q   <= dcnt_d;
         cnt_q    <= cnt_d;
         pcnt_q   <= pcnt_d;
         state_q  <= state_d;
      end
   end

   assign sensor_active = stable_q;
   assign active_count  = cnt_q;
   assign buzzerpin     = (state_q == BEEP_ON) || (state_q == CONT);

`ifdef HAPTIC_VIBE_EN
   logic vibe_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         vibe_q <= 1'b0;
      end else begin
         vibe_q <= enable && (cnt_q != '0);
      end
   end

   assign vibe_out = vibe_q;
`else
   assign vibe_out = 1'b0;
`endif

endmodule

// File: tb/tb_obstacle_alert_ctrl.sv
// Directed bench for obstacle_alert_ctrl at default parameters (N=3, DEB=4, ON=8, OFF=24).
module tb_obstacle_alert_ctrl;

   logic       clk;
   logic       rst_n;
   logic       enable;
   logic [2:0] sensorpin;
   logic [2:0] sensor_active;
   logic [1:0] active_count;
   logic       buzzerpin;
   logic       vibe_out;

   int n_cmp;
   int n_err;

   obstacle_alert_ctrl #(
      .NUM_SENSORS(3), .DEBOUNCE_CYCLES(4), .ON_CYCLES(8), .OFF_CYCLES(24)
   ) dut (
      .clk(clk), .rst_n(rst_n), .enable(enable), .sensorpin(sensorpin),
      .sensor_active(sensor_active), .active_count(active_count),
      .buzzerpin(buzzerpin), .vibe_out(vibe_out)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic tick(input int n = 1);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic wait_buz(input string tag, input logic val, input int bound);
      int k = 0;
      while (buzzerpin !== val && k < bound) begin
         tick();
         k++;
      end
      check(tag, buzzerpin, val);
   endtask

   task automatic run_len(input logic val, output int n);
      n = 0;
      while (buzzerpin === val && n < 200) begin
         n++;
         tick();
      end
   endtask

   int len;
   int seen_buz, seen_sa, vibe_hi, vibe_lo, buz_lo;

   initial begin
      n_cmp = 0;
      n_err = 0;
      rst_n = 1'b0;
      enable = 1'b1;
      sensorpin = 3'b111;
      tick(3);
      check("rst_sa", sensor_active, 0);
      check("rst_cnt", active_count, 0);
      check("rst_buz", buzzerpin, 0);
      check("rst_vibe", vibe_out, 0);

      rst_n = 1'b1;
      sensorpin = 3'b000;
      seen_buz = 0;
      for (int i = 0; i < 50; i++) begin
         tick();
         if (buzzerpin) seen_buz = 1;
      end
      check("idle_buz", seen_buz, 0);

      // 3-cycle glitch must be rejected
      sensorpin = 3'b001;
      tick(3);
      sensorpin = 3'b000;
      seen_buz = 0;
      seen_sa = 0;
      for (int i = 0; i < 20; i++) begin
         tick();
         if (buzzerpin) seen_buz = 1;
         if (sensor_active != 0) seen_sa = 1;
      end
      check("glitch_sa", seen_sa, 0);
      check("glitch_buz", seen_buz, 0);

      // held pin: accepted on 6th edge, buzzer on 8th
      sensorpin = 3'b001;
      tick(5);
      check("deb_sa_e5", sensor_active, 3'b000);
      tick();
      check("deb_sa_e6", sensor_active, 3'b001);
      tick();
      check("cnt_e7", active_count, 1);
      check("buz_e7", buzzerpin, 0);
      tick();
      check("buz_e8", buzzerpin, 1);
      run_len(1'b1, len); check("one_on_a", len, 8);
      run_len(1'b0, len); check("one_off_a", len, 24);
      run_len(1'b1, len); check("one_on_b", len, 8);
      run_len(1'b0, len); check("one_off_b", len, 24);

      vibe_hi = 0;
      vibe_lo = 0;
      for (int i = 0; i < 32; i++) begin
         if (vibe_out) vibe_hi = 1; else vibe_lo = 1;
         tick();
      end
`ifdef HAPTIC_VIBE_EN
      check("vibe_steady_lo", vibe_lo, 0);
      check("vibe_steady_hi", vibe_hi, 1);
`else
      check("vibe_tied_hi", vibe_hi, 0);
`endif

      // two channels: 8 on / 12 off
      sensorpin = 3'b011;
      tick(40);
      check("two_cnt", active_count, 2);
      wait_buz("two_sync_lo", 1'b0, 100);
      wait_buz("two_sync_hi", 1'b1, 100);
      run_len(1'b1, len); check("two_on", len, 8);
      run_len(1'b0, len); check("two_off", len, 12);

      // all channels: continuous tone
      sensorpin = 3'b111;
      tick(10);
      check("all_cnt", active_count, 3);
      check("all_sa", sensor_active, 3'b111);
      buz_lo = 0;
      for (int i = 0; i < 40; i++) begin
         if (!buzzerpin) buz_lo = 1;
         tick();
      end
      check("cont_lo", buz_lo, 0);

      // back to one channel: gap of 24 from CONT, then 8/24
      sensorpin = 3'b001;
      tick(7);
      check("drop_buz_e7", buzzerpin, 1);
      tick();
      check("drop_buz_e8", buzzerpin, 0);
      run_len(1'b0, len); check("drop_off", len, 24);
      run_len(1'b1, len); check("drop_on", len, 8);
      run_len(1'b0, len); check("drop_off2", len, 24);

      // enable gating
      enable = 1'b0;
      sensorpin = 3'b111;
      tick(10);
      check("dis_buz", buzzerpin, 0);
      check("dis_sa", sensor_active, 3'b111);
      check("dis_vibe", vibe_out, 0);
      enable = 1'b1;
      tick();
      check("en_buz", buzzerpin, 1);
`ifdef HAPTIC_VIBE_EN
      check("en_vibe", vibe_out, 1);
`endif

      // async reset during BEEP_ON
      sensorpin = 3'b001;
      wait_buz("rst_sync_lo", 1'b0, 100);
      wait_buz("rst_sync_hi", 1'b1, 100);
      #2;
      rst_n = 1'b0;
      #1;
      check("async_buz", buzzerpin, 0);
      check("async_sa", sensor_active, 0);
      check("async_cnt", active_count, 0);
      #1;
      rst_n = 1'b1;
      tick(5);
      check("rel_sa_e5", sensor_active, 3'b000);
      tick();
      check("rel_sa_e6", sensor_active, 3'b001);
      tick(2);
      check("rel_buz_e8", buzzerpin, 1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
